// File: rtl/program_loader.sv
// program_loader: streams a framed program image into instruction memory
// and holds the fetch pipeline until the image is complete.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   start             - one-cycle frame request, sampled only while idle
//   in_data/in_valid  - byte stream from the sender
//   in_ready          - loader takes a byte this cycle (decoded from state)
//   mem_write_enable  - one-cycle instruction memory write strobe
//   mem_address       - word-aligned byte address of the write
//   mem_write_data    - assembled 32-bit word, first byte in bits 31:24
//   cpu_hold          - high while a frame is being loaded
//   load_done         - one-cycle pulse at the end of every frame
//   load_error        - sticky result of the last frame
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int IW = $clog2(MAX_WORDS + 1);
    localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] n_words;
    logic [IW-1:0] word_idx;
    logic [1:0]    byte_cnt;
    logic [23:0]   word_lo;
    logic [7:0]    csum;

    // in_ready is only high in HEADER/DATA/CHECK, so in_valid inside
    // those states below is a completed transfer.
    assign in_ready = (state == HEADER) || (state == DATA) ||
                      (state == CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            n_words          <= '0;
            word_idx         <= '0;
            byte_cnt         <= '0;
            word_lo          <= '0;
            csum             <= '0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            cpu_hold         <= 1'b0;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
        end else begin
            mem_write_enable <= 1'b0;
            load_done        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= HEADER;
                        cpu_hold   <= 1'b1;
                        load_error <= 1'b0;
                        word_idx   <= '0;
                        byte_cnt   <= '0;
                        csum       <= '0;
                    end
                end
                HEADER: begin
                    if (in_valid) begin
                        if (in_data == 8'h00) begin
                            state <= CHECK;
                        end else if ({1'b0, in_data} > MAX_N) begin
                            load_error <= 1'b1;
                            load_done  <= 1'b1;
                            cpu_hold   <= 1'b0;
                            state      <= DONE;
                        end else begin
                            n_words <= IW'(in_data);
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (in_valid) begin
                        word_lo  <= {word_lo[15:0], in_data};
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Register the write now so the strobe is
                        // visible for exactly the WRITE cycle.
                        if (byte_cnt == 2'd3) begin
                            state            <= WRITE;
                            mem_write_enable <= 1'b1;
                            mem_address      <= ADDR_WIDTH'({word_idx, 2'b00});
                            mem_write_data   <= {word_lo, in_data};
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    byte_cnt <= '0;
                    if (word_idx + 1'b1 == n_words) begin
                        state <= CHECK;
                    end else begin
                        state <= DATA;
                    end
                end
                CHECK: begin
                    if (in_valid) begin
                        load_error <= (in_data != csum);
                        load_done  <= 1'b1;
                        cpu_hold   <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames against program_loader with
// hand-computed writes, checksum results and handshake timing.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_write_enable;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int total = 0;
    int bad   = 0;
    int hold_cnt = 0;
    logic [39:0] wr_q[$];

    localparam logic [39:0] W0 = {8'h00, 32'hE2110000};
    localparam logic [39:0] W1 = {8'h04, 32'hE0805183};

    program_loader #(.ADDR_WIDTH(8), .MAX_WORDS(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .cpu_hold         (cpu_hold),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] got,
                         input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Capture every write; the loader must never be taking bytes then.
    always @(posedge clk) begin
        if (cpu_hold) hold_cnt++;
        if (mem_write_enable) begin
            wr_q.push_back({mem_address, mem_write_data});
            check("rdy_in_wr", 40'(in_ready), 40'(0));
        end
    end

    task automatic do_start();
        wr_q.delete();
        hold_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        bit acc;
        in_data = b;
        for (int i = 0; i < 200; i++) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) return;
        end
        check("send_timeout", 40'(1), 40'(0));
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
        foreach (fr[i]) send(fr[i], gaps);
        in_valid = 1'b0;
    endtask

    task automatic check_wr(input int n, input logic [39:0] e0,
                            input logic [39:0] e1);
        check("n_writes", 40'(wr_q.size()), 40'(n));
        if (n >= 1 && wr_q.size() >= 1) check("write0", wr_q[0], e0);
        if (n >= 2 && wr_q.size() >= 2) check("write1", wr_q[1], e1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdy"},  40'(in_ready), 40'(0));
        check({tag, "_we"},   40'(mem_write_enable), 40'(0));
        check({tag, "_addr"}, 40'(mem_address), 40'(0));
        check({tag, "_data"}, 40'(mem_write_data), 40'(0));
        check({tag, "_hold"}, 40'(cpu_hold), 40'(0));
        check({tag, "_done"}, 40'(load_done), 40'(0));
        check({tag, "_err"},  40'(load_error), 40'(0));
    endtask

    logic [7:0] two_word[$] = '{8'h02, 8'hE2, 8'h11, 8'h00, 8'h00,
                                8'hE0, 8'h80, 8'h51, 8'h83, 8'h41};

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
        @(negedge clk);

        // Two-word load, in_valid held high
        do_start();
        check("t1_hold_on", 40'(cpu_hold), 40'(1));
        check("t1_rdy_on", 40'(in_ready), 40'(1));
        send_frame(two_word, 1'b0);
        check("t1_done", 40'(load_done), 40'(1));
        check("t1_hold_off", 40'(cpu_hold), 40'(0));
        check("t1_err", 40'(load_error), 40'(0));
        check("t1_hold_cycles", 40'(hold_cnt), 40'(12));
        check_wr(2, W0, W1);
        @(negedge clk);
        check("t1_done_pulse", 40'(load_done), 40'(0));
        check("t1_rdy_idle", 40'(in_ready), 40'(0));

        // Bad checksum on a one-word frame
        do_start();
        send_frame('{8'h01, 8'hE2, 8'h11, 8'h00, 8'h00, 8'h00}, 1'b0);
        check("t2_done", 40'(load_done), 40'(1));
        check("t2_err", 40'(load_error), 40'(1));
        check_wr(1, W0, 40'(0));
        @(negedge clk);
        check("t2_err_sticky", 40'(load_error), 40'(1));

        // Oversize header
        do_start();
        check("t3_err_clr", 40'(load_error), 40'(0));
        send_frame('{8'h41}, 1'b0);
        check("t3_done", 40'(load_done), 40'(1));
        check("t3_err", 40'(load_error), 40'(1));
        @(negedge clk);
        check("t3_rdy_after", 40'(in_ready), 40'(0));
        check_wr(0, 40'(0), 40'(0));

        // Same two-word frame with random in_valid gaps
        do_start();
        check("t4_err_clr", 40'(load_error), 40'(0));
        send_frame(two_word, 1'b1);
        check("t4_done", 40'(load_done), 40'(1));
        check("t4_err", 40'(load_error), 40'(0));
        check_wr(2, W0, W1);
        @(negedge clk);

        // Reset after two data bytes of word 0
        do_start();
        send_frame('{8'h02, 8'hE2, 8'h11}, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_zero("t5");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_wr(0, 40'(0), 40'(0));
        do_start();
        send_frame(two_word, 1'b0);
        check("t5_err", 40'(load_error), 40'(0));
        check_wr(2, W0, W1);
        @(negedge clk);

        // Empty frame
        do_start();
        send_frame('{8'h00, 8'h00}, 1'b0);
        check("t6_done", 40'(load_done), 40'(1));
        check("t6_err", 40'(load_error), 40'(0));
        check_wr(0, 40'(0), 40'(0));
        @(negedge clk);

        // start pulse while in DATA is ignored
        do_start();
        send_frame('{8'h01, 8'hE2}, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_rdy", 40'(in_ready), 40'(1));
        check("t7_hold", 40'(cpu_hold), 40'(1));
        send_frame('{8'h11, 8'h00, 8'h00, 8'hF3}, 1'b0);
        check("t7_done", 40'(load_done), 40'(1));
        check("t7_err", 40'(load_error), 40'(0));
        check_wr(1, W0, 40'(0));
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
